queue: RTL and testbench

In-order issue queue for the Tomasulo-style CPU core: holds operations whose operand is either a ready value or a pending producer label, and snoops the result broadcast bus to resolve pending labels. It delivers entries strictly in FIFO order and asserts `require` only when the head entry's operand is resolved. It sits between the dispatch stage (writer) and the execution/consumer stage (acknowledger).

---
 rtl/queue_pkg.sv | 14 +
 rtl/queue_entry.sv | 58 +++++
 rtl/queue.sv | 91 +++++++++
 tb/tb_queue.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared widths, the "operand ready" label and the entry layout for the issue queue.
package queue_pkg;

    localparam int DATA_W      = 32;
    localparam int LABEL_W     = 5;
    localparam int LABEL_READY = 0;

    typedef struct packed {
        logic               op;
        logic [DATA_W-1:0]  data;
        logic [LABEL_W-1:0] label;
    } entry_t;

endpackage

// File: rtl/queue_entry.sv
// One issue-queue slot: loaded by dispatch, resolved by a matching broadcast, cleared on pop.
module queue_entry #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 5
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               writeEn,
    input  logic               clearEn,
    input  logic               opIn,
    input  logic [DATA_W-1:0]  dataIn,
    input  logic [LABEL_W-1:0] labelIn,
    input  logic               bcEn,
    input  logic [LABEL_W-1:0] bcLabel,
    input  logic [DATA_W-1:0]  bcData,
    output logic               valid,
    output logic               op,
    output logic [DATA_W-1:0]  data,
    output logic [LABEL_W-1:0] label
);
    import queue_pkg::*;

    localparam logic [LABEL_W-1:0] READY = LABEL_W'(LABEL_READY);

    logic bypassHit;
    logic snoopHit;

    // A producer finishing in the same cycle as dispatch must not be missed.
    assign bypassHit = bcEn && (labelIn != READY) && (bcLabel == labelIn);
    assign snoopHit  = valid && bcEn && (bcLabel != READY) && (label == bcLabel);

    always_ff @(posedge clk) begin
        if (nRST) begin
            valid <= 1'b0;
            op    <= 1'b0;
            data  <= '0;
            label <= '0;
        end else if (writeEn) begin
            valid <= 1'b1;
            op    <= opIn;
            if (bypassHit) begin
                data  <= bcData;
                label <= READY;
            end else begin
                data  <= dataIn;
                label <= labelIn;
            end
        end else begin
            if (clearEn) begin
                valid <= 1'b0;
            end else if (snoopHit) begin
                data  <= bcData;
                label <= READY;
            end
        end
    end

endmodule

// File: rtl/queue.sv
// In-order issue queue: FIFO of {op, data, label} entries that snoop the result bus
// and offer the head to the consumer once its operand is resolved.
module queue #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 5
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               WEN,
    input  logic               opIN,
    input  logic [DATA_W-1:0]  dataIn,
    input  logic [LABEL_W-1:0] labelIn,
    input  logic               BCEN,
    input  logic [LABEL_W-1:0] BClabel,
    input  logic [DATA_W-1:0]  BCdata,
    input  logic               requireAC,
    output logic               isFull,
    output logic               require,
    output logic               opOut,
    output logic [DATA_W-1:0]  dataOut,
    output logic [LABEL_W-1:0] labelOut
);
    import queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic               entryValid [DEPTH];
    logic               entryOp    [DEPTH];
    logic [DATA_W-1:0]  entryData  [DEPTH];
    logic [LABEL_W-1:0] entryLabel [DEPTH];

    logic doPush;
    logic doPop;
    logic headValid;

    assign isFull    = (count == CNT_W'(DEPTH));
    assign headValid = entryValid[head];
    assign require   = headValid && (entryLabel[head] == LABEL_W'(LABEL_READY));
    assign doPush    = WEN && !isFull;
    assign doPop     = requireAC && require;

    // Empty queue presents all-zero head fields.
    assign opOut    = headValid ? entryOp[head]    : 1'b0;
    assign dataOut  = headValid ? entryData[head]  : '0;
    assign labelOut = headValid ? entryLabel[head] : '0;

    for (genvar i = 0; i < DEPTH; i++) begin : gSlot
        queue_entry #(
            .DATA_W  (DATA_W),
            .LABEL_W (LABEL_W)
        ) uEntry (
            .clk     (clk),
            .nRST    (nRST),
            .writeEn (doPush && (tail == PTR_W'(i))),
            .clearEn (doPop && (head == PTR_W'(i))),
            .opIn    (opIN),
            .dataIn  (dataIn),
            .labelIn (labelIn),
            .bcEn    (BCEN),
            .bcLabel (BClabel),
            .bcData  (BCdata),
            .valid   (entryValid[i]),
            .op      (entryOp[i]),
            .data    (entryData[i]),
            .label   (entryLabel[i])
        );
    end

    always_ff @(posedge clk) begin
        if (nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (doPush) tail <= tail + PTR_W'(1);
            if (doPop)  head <= head + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_queue.sv
// Directed bench for the issue queue: hand-computed expectations checked after each edge.
module tb_queue;

    localparam int DEPTH   = 8;
    localparam int DATA_W  = 32;
    localparam int LABEL_W = 5;

    logic               clk = 1'b0;
    logic               nRST;
    logic               WEN;
    logic               opIN;
    logic [DATA_W-1:0]  dataIn;
    logic [LABEL_W-1:0] labelIn;
    logic               BCEN;
    logic [LABEL_W-1:0] BClabel;
    logic [DATA_W-1:0]  BCdata;
    logic               requireAC;
    logic               isFull;
    logic               require;
    logic               opOut;
    logic [DATA_W-1:0]  dataOut;
    logic [LABEL_W-1:0] labelOut;

    int total = 0;
    int bad   = 0;

    queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LABEL_W(LABEL_W)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .WEN       (WEN),
        .opIN      (opIN),
        .dataIn    (dataIn),
        .labelIn   (labelIn),
        .BCEN      (BCEN),
        .BClabel   (BClabel),
        .BCdata    (BCdata),
        .requireAC (requireAC),
        .isFull    (isFull),
        .require   (require),
        .opOut     (opOut),
        .dataOut   (dataOut),
        .labelOut  (labelOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        WEN = 1'b0; opIN = 1'b0; dataIn = '0; labelIn = '0;
        BCEN = 1'b0; BClabel = '0; BCdata = '0; requireAC = 1'b0;
    endtask

    task automatic push(input logic op, input int d, input int l);
        WEN = 1'b1; opIN = op; dataIn = DATA_W'(d); labelIn = LABEL_W'(l);
    endtask

    task automatic bcast(input int l, input int d);
        BCEN = 1'b1; BClabel = LABEL_W'(l); BCdata = DATA_W'(d);
    endtask

    task automatic head(input string tag, input logic r, input logic op, input int d, input int l);
        check({tag, ".require"}, 64'(require), 64'(r));
        check({tag, ".op"},      64'(opOut),   64'(op));
        check({tag, ".data"},    64'(dataOut), 64'(d));
        check({tag, ".label"},   64'(labelOut), 64'(l));
    endtask

    initial begin
        idle();
        nRST = 1'b1;
        step();
        step();
        nRST = 1'b0;
        step();
        head("reset", 1'b0, 1'b0, 0, 0);
        check("reset.isFull", 64'(isFull), 64'd0);

        // Two pending entries, then resolve the head while a premature pop is asserted.
        push(1'b1, 20, 4); step(); idle();
        head("push1", 1'b0, 1'b1, 20, 4);
        push(1'b0, 30, 5); step(); idle();
        head("push2", 1'b0, 1'b1, 20, 4);
        bcast(4, 25); requireAC = 1'b1; step(); idle();
        head("bc4", 1'b1, 1'b1, 25, 0);
        bcast(5, 1); requireAC = 1'b1; step(); idle();
        head("bc5pop", 1'b1, 1'b0, 1, 0);
        requireAC = 1'b1; step(); idle();
        head("drain1", 1'b0, 1'b0, 0, 0);

        // Ready push, then simultaneous push and pop.
        push(1'b0, 40, 0); step(); idle();
        head("ready", 1'b1, 1'b0, 40, 0);
        push(1'b1, 16, 8); requireAC = 1'b1; step(); idle();
        head("pushpop", 1'b0, 1'b1, 16, 8);
        bcast(8, 7); step(); idle();
        head("bc8", 1'b1, 1'b1, 7, 0);
        requireAC = 1'b1; step(); idle();
        head("drain2", 1'b0, 1'b0, 0, 0);

        // Dispatch-time bypass, and a label-0 broadcast that must not touch ready entries.
        push(1'b0, 99, 2); bcast(2, 10); step(); idle();
        head("bypass", 1'b1, 1'b0, 10, 0);
        requireAC = 1'b1; step(); idle();
        push(1'b1, 50, 0); step(); idle();
        bcast(0, 77); step(); idle();
        head("bc0", 1'b1, 1'b1, 50, 0);
        requireAC = 1'b1; step(); idle();
        head("drain3", 1'b0, 1'b0, 0, 0);

        // Fill to DEPTH, reject an extra push, and a push during the pop from full.
        for (int i = 0; i < DEPTH; i++) begin
            push(1'b0, 100 + i, 0); step(); idle();
            check($sformatf("fill%0d.isFull", i), 64'(isFull), 64'(i == DEPTH - 1));
        end
        push(1'b0, 999, 0); step(); idle();
        check("overfill.isFull", 64'(isFull), 64'd1);
        head("overfill", 1'b1, 1'b0, 100, 0);
        push(1'b0, 555, 0); requireAC = 1'b1; step(); idle();
        check("popfull.isFull", 64'(isFull), 64'd0);
        for (int k = 1; k < DEPTH; k++) begin
            check($sformatf("order%0d", k), 64'(dataOut), 64'(100 + k));
            requireAC = 1'b1; step(); idle();
        end
        head("drain4", 1'b0, 1'b0, 0, 0);

        // Wrap-around streaming: 2*DEPTH pushes overlapped with pops.
        push(1'b1, 200, 0); step(); idle();
        for (int i = 1; i < 2 * DEPTH; i++) begin
            check($sformatf("wrap%0d", i - 1), 64'(dataOut), 64'(200 + i - 1));
            push(1'b1, 200 + i, 0); requireAC = 1'b1; step(); idle();
        end
        head("wraplast", 1'b1, 1'b1, 200 + 2 * DEPTH - 1, 0);
        requireAC = 1'b1; step(); idle();
        head("drain5", 1'b0, 1'b0, 0, 0);

        // Reset with pending entries; broadcast and push in the reset cycle are dropped.
        push(1'b1, 60, 3); step(); idle();
        push(1'b0, 61, 0); step(); idle();
        nRST = 1'b1; bcast(3, 5); push(1'b1, 62, 0); step(); idle();
        nRST = 1'b0;
        head("midreset", 1'b0, 1'b0, 0, 0);
        check("midreset.isFull", 64'(isFull), 64'd0);
        push(1'b0, 70, 3); step(); idle();
        head("postreset", 1'b0, 1'b0, 70, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
